// File: rtl/caxi4interconnect_cdc_rd_side.sv
`default_nettype none
// ============================================================================
// Module  : caxi4interconnect_cdc_rd_side
// Brief   : Read side of a Gray-pointer async FIFO: write-pointer synchronizer,
//           empty detection, read pointer and one-entry output valid stage.
// Revision: 1.0 - initial release
// ============================================================================
module caxi4interconnect_cdc_rd_side #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  terminate,
  input  logic [ADDR_WIDTH-1:0] wrPtr_gray,
  input  logic                  infoOutReady,
  output logic [ADDR_WIDTH-1:0] rdPtr_gray,
  output logic [ADDR_WIDTH-1:0] rdAddr,
  output logic                  fifoRe,
  output logic                  infoOutValid
);

  localparam logic [ADDR_WIDTH-1:0] c_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] c_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_wrPtrS1;
  logic [ADDR_WIDTH-1:0] r_wrPtrS2;
  logic [ADDR_WIDTH-1:0] r_rdPtrBin;
  logic [ADDR_WIDTH-1:0] r_rdPtrGray;
  logic                  r_infoOutValid;

  logic [ADDR_WIDTH-1:0] w_nextBin;
  logic [ADDR_WIDTH-1:0] w_nextGray;
  logic                  w_empty;
  logic                  w_fifoRe;

  // Empty compares the synchronized write pointer against the registered Gray
  // read pointer, so both sides of the comparison are flop outputs.
  assign w_empty    = (r_wrPtrS2 == r_rdPtrGray);
  assign w_nextBin  = r_rdPtrBin + c_ONE;
  assign w_nextGray = w_nextBin ^ (w_nextBin >> 1);

  // Reads are suppressed during reset and flush so no stray RAM access occurs.
  assign w_fifoRe = rst && !terminate && !w_empty &&
                    (!r_infoOutValid || infoOutReady);

  always_ff @(posedge clk) begin
    if (!rst || terminate) begin
      r_wrPtrS1      <= c_ZERO;
      r_wrPtrS2      <= c_ZERO;
      r_rdPtrBin     <= c_ZERO;
      r_rdPtrGray    <= c_ZERO;
      r_infoOutValid <= 1'b0;
    end else begin
      r_wrPtrS1 <= wrPtr_gray;
      r_wrPtrS2 <= r_wrPtrS1;
      if (w_fifoRe) begin
        r_rdPtrBin  <= w_nextBin;
        r_rdPtrGray <= w_nextGray;
      end
      if (w_fifoRe) begin
        r_infoOutValid <= 1'b1;
      end else if (infoOutReady) begin
        r_infoOutValid <= 1'b0;
      end
    end
  end

  assign rdPtr_gray   = r_rdPtrGray;
  assign rdAddr       = r_rdPtrBin;
  assign fifoRe       = w_fifoRe;
  assign infoOutValid = r_infoOutValid;

endmodule
`default_nettype wire

// File: tb/tb_caxi4interconnect_cdc_rd_side.sv
`default_nettype none
// ============================================================================
// Module  : tb_caxi4interconnect_cdc_rd_side
// Brief   : Directed self-checking bench for the CDC FIFO read side.
// Revision: 1.0 - initial release
// ============================================================================
module tb_caxi4interconnect_cdc_rd_side;

  logic       clk;
  logic       rst;
  logic       terminate;
  logic [2:0] wrPtr_gray;
  logic       infoOutReady;
  logic [2:0] rdPtr_gray;
  logic [2:0] rdAddr;
  logic       fifoRe;
  logic       infoOutValid;

  int n_checks;
  int n_fail;

  caxi4interconnect_cdc_rd_side #(.ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .terminate    (terminate),
    .wrPtr_gray   (wrPtr_gray),
    .infoOutReady (infoOutReady),
    .rdPtr_gray   (rdPtr_gray),
    .rdAddr       (rdAddr),
    .fifoRe       (fifoRe),
    .infoOutValid (infoOutValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; terminate = 1'b0; wrPtr_gray = 3'b000; infoOutReady = 1'b1;
    tick(); tick();
    n_checks++; if (infoOutValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", infoOutValid); end
    n_checks++; if (rdPtr_gray !== 3'b000) begin n_fail++; $display("FAIL reset_gray: got %b expected 000", rdPtr_gray); end
    n_checks++; if (rdAddr !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", rdAddr); end
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL reset_fifoRe: got %b expected 0", fifoRe); end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL idle_fifoRe[%0d]: got %b expected 0", i, fifoRe); end
      n_checks++; if (infoOutValid !== 1'b0) begin n_fail++; $display("FAIL idle_valid[%0d]: got %b expected 0", i, infoOutValid); end
      n_checks++; if (rdPtr_gray !== 3'b000) begin n_fail++; $display("FAIL idle_gray[%0d]: got %b expected 000", i, rdPtr_gray); end
    end
  endtask

  task automatic test_single();
    wrPtr_gray = 3'b001;
    tick();
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL single_s1_fifoRe: got %b expected 0", fifoRe); end
    tick();
    n_checks++; if (fifoRe !== 1'b1) begin n_fail++; $display("FAIL single_fifoRe: got %b expected 1", fifoRe); end
    n_checks++; if (infoOutValid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b expected 0", infoOutValid); end
    tick();
    n_checks++; if (infoOutValid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", infoOutValid); end
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL single_fifoRe_off: got %b expected 0", fifoRe); end
    n_checks++; if (rdPtr_gray !== 3'b001) begin n_fail++; $display("FAIL single_gray: got %b expected 001", rdPtr_gray); end
    n_checks++; if (rdAddr !== 3'd1) begin n_fail++; $display("FAIL single_addr: got %0d expected 1", rdAddr); end
    tick();
    n_checks++; if (infoOutValid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", infoOutValid); end
  endtask

  task automatic test_burst();
    wrPtr_gray = 3'b000; rst = 1'b0;
    tick();
    rst = 1'b1; wrPtr_gray = 3'b100;
    tick(); tick();
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (fifoRe !== 1'b1) begin n_fail++; $display("FAIL burst_fifoRe[%0d]: got %b expected 1", i, fifoRe); end
      n_checks++; if (rdAddr !== 3'(i)) begin n_fail++; $display("FAIL burst_addr[%0d]: got %0d expected %0d", i, rdAddr, i); end
      n_checks++; if (infoOutValid !== (i != 0)) begin n_fail++; $display("FAIL burst_valid[%0d]: got %b expected %b", i, infoOutValid, (i != 0)); end
      tick();
    end
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL burst_empty_fifoRe: got %b expected 0", fifoRe); end
    n_checks++; if (rdAddr !== 3'd7) begin n_fail++; $display("FAIL burst_end_addr: got %0d expected 7", rdAddr); end
    n_checks++; if (rdPtr_gray !== 3'b100) begin n_fail++; $display("FAIL burst_end_gray: got %b expected 100", rdPtr_gray); end
    n_checks++; if (infoOutValid !== 1'b1) begin n_fail++; $display("FAIL burst_end_valid: got %b expected 1", infoOutValid); end
    tick();
    n_checks++; if (rdAddr !== 3'd7) begin n_fail++; $display("FAIL burst_hold_addr: got %0d expected 7", rdAddr); end
    n_checks++; if (infoOutValid !== 1'b0) begin n_fail++; $display("FAIL burst_valid_drop: got %b expected 0", infoOutValid); end
  endtask

  task automatic test_wrap();
    logic [2:0] expAddr [3];
    logic [2:0] expGray [3];
    logic [2:0] prevGray;
    expAddr = '{3'd7, 3'd0, 3'd1};
    expGray = '{3'b000, 3'b001, 3'b011};
    wrPtr_gray = 3'b011;
    tick(); tick();
    prevGray = rdPtr_gray;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (fifoRe !== 1'b1) begin n_fail++; $display("FAIL wrap_fifoRe[%0d]: got %b expected 1", i, fifoRe); end
      n_checks++; if (rdAddr !== expAddr[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, rdAddr, expAddr[i]); end
      tick();
      n_checks++; if (rdPtr_gray !== expGray[i]) begin n_fail++; $display("FAIL wrap_gray[%0d]: got %b expected %b", i, rdPtr_gray, expGray[i]); end
      n_checks++; if ($countones(prevGray ^ rdPtr_gray) !== 1) begin n_fail++; $display("FAIL wrap_onebit[%0d]: got %b->%b expected one-bit change", i, prevGray, rdPtr_gray); end
      prevGray = rdPtr_gray;
    end
    n_checks++; if (rdAddr !== 3'd2) begin n_fail++; $display("FAIL wrap_end_addr: got %0d expected 2", rdAddr); end
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL wrap_end_fifoRe: got %b expected 0", fifoRe); end
    tick();
  endtask

  task automatic test_stall();
    infoOutReady = 1'b0; wrPtr_gray = 3'b111;
    tick(); tick();
    n_checks++; if (fifoRe !== 1'b1) begin n_fail++; $display("FAIL stall_first_fifoRe: got %b expected 1", fifoRe); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL stall_fifoRe[%0d]: got %b expected 0", i, fifoRe); end
      n_checks++; if (rdAddr !== 3'd3) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0d expected 3", i, rdAddr); end
      n_checks++; if (infoOutValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, infoOutValid); end
      tick();
    end
    infoOutReady = 1'b1;
    #1;
    n_checks++; if (fifoRe !== 1'b1) begin n_fail++; $display("FAIL drain0_fifoRe: got %b expected 1", fifoRe); end
    tick();
    n_checks++; if (fifoRe !== 1'b1) begin n_fail++; $display("FAIL drain1_fifoRe: got %b expected 1", fifoRe); end
    n_checks++; if (rdAddr !== 3'd4) begin n_fail++; $display("FAIL drain1_addr: got %0d expected 4", rdAddr); end
    tick();
    n_checks++; if (rdAddr !== 3'd5) begin n_fail++; $display("FAIL drain_end_addr: got %0d expected 5", rdAddr); end
    n_checks++; if (rdPtr_gray !== 3'b111) begin n_fail++; $display("FAIL drain_end_gray: got %b expected 111", rdPtr_gray); end
    n_checks++; if (infoOutValid !== 1'b1) begin n_fail++; $display("FAIL drain_end_valid: got %b expected 1", infoOutValid); end
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL drain_end_fifoRe: got %b expected 0", fifoRe); end
    tick();
  endtask

  task automatic test_terminate();
    infoOutReady = 1'b0; wrPtr_gray = 3'b000;
    tick(); tick(); tick();
    n_checks++; if (infoOutValid !== 1'b1) begin n_fail++; $display("FAIL term_pre_valid: got %b expected 1", infoOutValid); end
    n_checks++; if (rdAddr !== 3'd6) begin n_fail++; $display("FAIL term_pre_addr: got %0d expected 6", rdAddr); end
    terminate = 1'b1; infoOutReady = 1'b1;
    #1;
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL term_fifoRe: got %b expected 0", fifoRe); end
    tick();
    n_checks++; if (infoOutValid !== 1'b0) begin n_fail++; $display("FAIL term_valid: got %b expected 0", infoOutValid); end
    n_checks++; if (rdPtr_gray !== 3'b000) begin n_fail++; $display("FAIL term_gray: got %b expected 000", rdPtr_gray); end
    n_checks++; if (rdAddr !== 3'd0) begin n_fail++; $display("FAIL term_addr: got %0d expected 0", rdAddr); end
    n_checks++; if (dut.r_wrPtrS2 !== 3'b000) begin n_fail++; $display("FAIL term_wrPtr_s2: got %b expected 000", dut.r_wrPtrS2); end
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL term_hold_fifoRe: got %b expected 0", fifoRe); end
    terminate = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL term_after_fifoRe: got %b expected 0", fifoRe); end
  endtask

  task automatic test_reset_mid();
    infoOutReady = 1'b0; wrPtr_gray = 3'b011;
    tick(); tick(); tick();
    n_checks++; if (infoOutValid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", infoOutValid); end
    rst = 1'b0; terminate = 1'b1; infoOutReady = 1'b1;
    #1;
    n_checks++; if (infoOutValid !== 1'b1) begin n_fail++; $display("FAIL rstmid_async_valid: got %b expected 1", infoOutValid); end
    n_checks++; if (rdAddr !== 3'd1) begin n_fail++; $display("FAIL rstmid_async_addr: got %0d expected 1", rdAddr); end
    n_checks++; if (fifoRe !== 1'b0) begin n_fail++; $display("FAIL rstmid_fifoRe: got %b expected 0", fifoRe); end
    tick();
    n_checks++; if (infoOutValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", infoOutValid); end
    n_checks++; if (rdAddr !== 3'd0) begin n_fail++; $display("FAIL rstmid_addr: got %0d expected 0", rdAddr); end
    n_checks++; if (rdPtr_gray !== 3'b000) begin n_fail++; $display("FAIL rstmid_gray: got %b expected 000", rdPtr_gray); end
    rst = 1'b1; terminate = 1'b0; wrPtr_gray = 3'b000;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; terminate = 1'b0; wrPtr_gray = 3'b000; infoOutReady = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_stall();
    test_terminate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
